// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and sizing for the instruction-memory block server
package imem_pkg;

    localparam int ADDR_W          = 6;
    localparam int BLOCK_W         = 128;
    localparam int WORD_W          = 32;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int LATENCY         = 40;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } imem_state_t;

endpackage

// File: rtl/imem_block_ram.sv
// rtl/imem_block_ram.sv - block-wide instruction store with word write port and async block read
module imem_block_ram #(
    parameter int ADDR_W  = 6,
    parameter int BLOCK_W = 128,
    parameter int WORD_W  = 32
) (
    input  logic               CLK,
    input  logic               we,
    input  logic [ADDR_W+1:0]  waddr,
    input  logic [WORD_W-1:0]  wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [BLOCK_W-1:0] rdata
);

    logic [BLOCK_W-1:0] mem [2**ADDR_W];

    // Word-granular preload; contents are deliberately not reset so boot data survives RESET
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr[ADDR_W+1:2]][WORD_W*waddr[1:0] +: WORD_W] <= wdata;
        end
    end

    // Asynchronous block read; a same-edge write is seen only on the following cycle
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/imem_block_server.sv
// rtl/imem_block_server.sv - fixed-latency 128-bit block responder for the icache refill port
module imem_block_server #(
    parameter int ADDR_W  = imem_pkg::ADDR_W,
    parameter int BLOCK_W = imem_pkg::BLOCK_W,
    parameter int LATENCY = imem_pkg::LATENCY
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               read,
    input  logic [ADDR_W-1:0]  address,
    output logic [BLOCK_W-1:0] readinst,
    output logic               busywait,
    input  logic               load_en,
    input  logic [ADDR_W+1:0]  load_addr,
    input  logic [31:0]        load_word
);

    import imem_pkg::*;

    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

    imem_state_t        state;
    imem_state_t        state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]  addr_q;
    logic [BLOCK_W-1:0] ram_rdata;
    logic               accept;
    logic               last_busy;

    assign accept    = (state == IDLE) && read;
    assign last_busy = (state == BUSY) && (cnt == CNT_W'(1));

    imem_block_ram #(
        .ADDR_W  (ADDR_W),
        .BLOCK_W (BLOCK_W),
        .WORD_W  (WORD_W)
    ) u_ram (
        .CLK   (CLK),
        .we    (load_en),
        .waddr (load_addr),
        .wdata (load_word),
        .raddr (addr_q),
        .rdata (ram_rdata)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; RESP always returns to IDLE regardless of read
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (read) state_nxt = BUSY;
            BUSY:    if (cnt == CNT_W'(1)) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // busywait rises in the request cycle itself so the icache never sees a false completion
    always_comb begin
        busywait = (state == BUSY) || (state == IDLE && read);
    end

    // Latency counter: loaded on acceptance, counts down to the last BUSY cycle
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CNT_W'(LATENCY - 1);
        end else if ((state == BUSY) && !last_busy) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Address captured at acceptance so later address changes cannot redirect the read
    always_ff @(posedge CLK) begin
        if (RESET) begin
            addr_q <= '0;
        end else if (accept) begin
            addr_q <= address;
        end
    end

    // Output block register, updated only on the BUSY->RESP edge and held otherwise
    always_ff @(posedge CLK) begin
        if (RESET) begin
            readinst <= '0;
        end else if (last_busy) begin
            readinst <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_imem_block_server.sv
// tb/tb_imem_block_server.sv - scoreboard bench for imem_block_server
module tb_imem_block_server;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         read;
    logic [5:0]   address;
    logic [127:0] readinst;
    logic         busywait;
    logic         load_en;
    logic [7:0]   load_addr;
    logic [31:0]  load_word;

    typedef struct {
        logic [127:0] data;
        int           len;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   run    = 0;

    localparam logic [127:0] B5     = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] B5_NEW = 128'h44444444_DEADBEEF_22222222_11111111;
    localparam logic [127:0] B7     = 128'h7777000D_7777000C_7777000B_7777000A;
    localparam logic [127:0] B9     = 128'h99990004_99990003_99990002_99990001;

    imem_block_server dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .read      (read),
        .address   (address),
        .readinst  (readinst),
        .busywait  (busywait),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_word (load_word)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [127:0] d, input int len);
        exp_t e;
        e.data = d;
        e.len  = len;
        exp_q.push_back(e);
    endtask

    // Monitor: a falling busywait marks a response (or an aborted request); compare it
    always @(negedge CLK) begin
        if (busywait === 1'b1) begin
            run++;
        end else if (run > 0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_response: got %h after %0d busy cycles, none expected", readinst, run);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_data", readinst, e.data);
                chk("busy_len", 128'(run), 128'(e.len));
            end
            run = 0;
        end
    end

    task automatic load_block(input logic [5:0] b, input logic [127:0] d);
        for (int k = 0; k < 4; k++) begin
            load_en   = 1'b1;
            load_addr = {b, 2'(k)};
            load_word = d[32*k +: 32];
            @(posedge CLK); #1;
        end
        load_en = 1'b0;
    endtask

    // One request issued in cycle c0; per-cycle side actions keyed by cycle index k
    task automatic txn(input logic [5:0] a, input int hold, input int chg_at, input logic [5:0] a2,
                       input int load_at, input int rst_at, input int total);
        read    = 1'b1;
        address = a;
        for (int k = 1; k < total; k++) begin
            @(posedge CLK); #1;
            if (k == hold) read = 1'b0;
            if (k == chg_at) address = a2;
            load_en   = (k == load_at);
            load_addr = 8'h16;
            load_word = 32'hDEADBEEF;
            RESET     = (k == rst_at);
            if (rst_at > 0 && k == rst_at + 1) begin
                @(negedge CLK);
                chk("reset_readinst", readinst, '0);
                chk("reset_busywait", 128'(busywait), 128'(0));
            end
        end
        read    = 1'b0;
        load_en = 1'b0;
        @(posedge CLK); #1;
    endtask

    initial begin
        RESET     = 1'b1;
        read      = 1'b0;
        address   = '0;
        load_en   = 1'b0;
        load_addr = '0;
        load_word = '0;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        chk("init_readinst", readinst, '0);
        chk("init_busywait", 128'(busywait), 128'(0));
        @(posedge CLK); #1;

        load_block(6'd5, B5);
        load_block(6'd7, B7);
        load_block(6'd9, B9);

        // 1: basic 40-cycle read of block 5
        push(B5, 40);
        txn(6'd5, 40, -1, 6'd0, -1, -1, 44);

        // 2: address moves to 9 during BUSY
        push(B5, 40);
        txn(6'd5, 1, 5, 6'd9, -1, -1, 44);

        // 3: read dropped at cycle 10
        push(B9 ^ B9 ^ B5, 40);
        txn(6'd5, 10, -1, 6'd0, -1, -1, 44);
        @(negedge CLK);
        chk("idle_after_resp", 128'(busywait), 128'(0));
        @(posedge CLK); #1;

        // 4: read held through RESP at block 7 starts a second transaction
        push(B7, 40);
        push(B7, 40);
        txn(6'd7, 42, -1, 6'd0, -1, -1, 86);

        // 5: RESET at cycle 20 aborts; storage survives
        push('0, 21);
        txn(6'd5, 1, -1, 6'd0, -1, 20, 44);
        push(B5, 40);
        txn(6'd5, 1, -1, 6'd0, -1, -1, 44);

        // 6: preload on the RESP edge is not visible until the next read
        push(B5, 40);
        txn(6'd5, 1, -1, 6'd0, 39, -1, 44);
        push(B5_NEW, 40);
        txn(6'd5, 1, -1, 6'd0, -1, -1, 44);

        repeat (4) @(posedge CLK);
        chk("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
